timing_counter: RTL and testbench

- Parametrised successor to the team's basic `Counter`, for VGA timing chains.
- Adds:
  - runtime terminal and rollover values;
  - up/down direction, synchronous clear and parallel load;
  - a combinational carry for cascading (horizontal counter drives vertical counter `clk_en`);
  - NUM_CMP registered window-compare flags, for sync, blanking and porch regions.
- One instance per axis inside the VGA timing generator.

---
 rtl/timing_pkg.sv | 17 +
 rtl/timing_counter_if.sv | 30 +++
 rtl/window_cmp.sv | 34 +++
 rtl/timing_counter.sv | 85 ++++++++
 tb/tb_timing_counter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timing_pkg.sv
// Shared constants for the VGA timing chain: count direction encoding and
// default 640x480 horizontal/vertical timing points.
package timing_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int unsigned H_TOTAL_M1 = 799;
    localparam int unsigned V_TOTAL_M1 = 524;
    localparam int unsigned H_SYNC_LO  = 656;
    localparam int unsigned H_SYNC_HI  = 751;
    localparam int unsigned V_SYNC_LO  = 490;
    localparam int unsigned V_SYNC_HI  = 491;

endpackage

// File: rtl/timing_counter_if.sv
// Control/status bundle of one timing_counter axis; master drives controls,
// slave is the counter.
interface timing_counter_if #(
    parameter int unsigned SIZE    = 16,
    parameter int unsigned NUM_CMP = 2
);
    logic                      clk_en;
    logic                      sync_clr;
    logic                      load;
    logic [SIZE-1:0]           load_val;
    logic                      dir;
    logic [SIZE-1:0]           tc_val;
    logic [SIZE-1:0]           rc_val;
    logic [NUM_CMP*SIZE-1:0]   cmp_lo;
    logic [NUM_CMP*SIZE-1:0]   cmp_hi;
    logic [SIZE-1:0]           count;
    logic                      tc_pulse;
    logic                      carry_out;
    logic [NUM_CMP-1:0]        cmp_in;

    modport master (
        output clk_en, sync_clr, load, load_val, dir, tc_val, rc_val, cmp_lo, cmp_hi,
        input  count, tc_pulse, carry_out, cmp_in
    );

    modport slave (
        input  clk_en, sync_clr, load, load_val, dir, tc_val, rc_val, cmp_lo, cmp_hi,
        output count, tc_pulse, carry_out, cmp_in
    );
endinterface

// File: rtl/window_cmp.sv
// Registered inclusive window compare (lo <= value <= hi); an empty window
// (lo > hi) never matches.
module window_cmp #(
    parameter int unsigned     SIZE    = 16,
    parameter logic [SIZE-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            armed,
    input  logic [SIZE-1:0] lo,
    input  logic [SIZE-1:0] hi,
    input  logic [SIZE-1:0] next_val,
    output logic            hit
);

    logic hit_q;
    logic rst_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= (lo <= next_val) && (next_val <= hi);
        end
    end

    // Until the first edge after reset the count sits at RST_VAL, so the flag
    // follows the live bounds against that value instead of a stale register.
    always_comb begin
        rst_hit = (lo <= RST_VAL) && (RST_VAL <= hi);
        hit     = armed ? hit_q : rst_hit;
    end

endmodule

// File: rtl/timing_counter.sv
// Programmable up/down timing counter with terminal/rollover values, cascade
// carry and registered window-compare flags; one instance per VGA axis.
module timing_counter
    import timing_pkg::*;
#(
    parameter int unsigned SIZE    = 16,
    parameter int unsigned IC      = 0,
    parameter int unsigned NUM_CMP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    timing_counter_if.slave   bus
);

    localparam logic [SIZE-1:0] IC_V = SIZE'(IC);

    logic [SIZE-1:0]    count_q;
    logic [SIZE-1:0]    count_d;
    logic               tc_pulse_q;
    logic               armed_q;
    logic               term;
    logic               carry;
    logic [NUM_CMP-1:0] cmp_flags;

    // armed_q holds off the first edge after reset release, so stepping
    // starts on the second rising edge.
    always_comb begin
        if (bus.dir == DIR_DOWN) begin
            term = (count_q <= bus.tc_val);
        end else begin
            term = (count_q >= bus.tc_val);
        end
        carry = armed_q & bus.clk_en & term & ~bus.sync_clr & ~bus.load;

        count_d = count_q;
        if (armed_q) begin
            if (bus.sync_clr) begin
                count_d = IC_V;
            end else if (bus.load) begin
                count_d = bus.load_val;
            end else if (carry) begin
                count_d = bus.rc_val;
            end else if (bus.clk_en) begin
                if (bus.dir == DIR_DOWN) begin
                    count_d = count_q - 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= IC_V;
            tc_pulse_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_pulse_q <= carry;
            armed_q    <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
        window_cmp #(
            .SIZE    (SIZE),
            .RST_VAL (IC_V)
        ) u_window_cmp (
            .clk      (clk),
            .rst_n    (rst_n),
            .armed    (armed_q),
            .lo       (bus.cmp_lo[i*SIZE +: SIZE]),
            .hi       (bus.cmp_hi[i*SIZE +: SIZE]),
            .next_val (count_d),
            .hit      (cmp_flags[i])
        );
    end

    assign bus.count     = count_q;
    assign bus.tc_pulse  = tc_pulse_q;
    assign bus.carry_out = carry;
    assign bus.cmp_in    = cmp_flags;

endmodule

// File: tb/tb_timing_counter.sv
// Self-checking bench for timing_counter: vector table, hand sequences and
// randomized stimulus against a behavioural model.
module tb_timing_counter;
    import timing_pkg::*;

    localparam int unsigned SIZE    = 10;
    localparam int unsigned NUM_CMP = 2;
    localparam int unsigned IC      = 0;
    localparam int          MODV    = 1 << SIZE;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    timing_counter_if #(.SIZE(SIZE), .NUM_CMP(NUM_CMP)) bus ();

    timing_counter #(.SIZE(SIZE), .IC(IC), .NUM_CMP(NUM_CMP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_count;
    bit m_pulse;
    bit m_armed;
    bit m_flag [NUM_CMP];

    typedef struct {
        bit en; bit clr; bit ld; int lv; bit dir; int tc; int rc;
        bit exp_carry; int exp_count; bit exp_pulse;
    } vec_t;
    vec_t vecs [20];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lo_of(input int i);
        return int'(bus.cmp_lo[i*SIZE +: SIZE]);
    endfunction

    function automatic int hi_of(input int i);
        return int'(bus.cmp_hi[i*SIZE +: SIZE]);
    endfunction

    function automatic bit in_win(input int i, input int v);
        return (lo_of(i) <= v) && (v <= hi_of(i));
    endfunction

    function automatic bit model_carry();
        bit t;
        if (!m_armed) return 1'b0;
        t = bus.dir ? (m_count <= int'(bus.tc_val)) : (m_count >= int'(bus.tc_val));
        return bus.clk_en && t && !bus.sync_clr && !bus.load;
    endfunction

    task automatic model_reset();
        m_count = IC;
        m_pulse = 1'b0;
        m_armed = 1'b0;
    endtask

    task automatic model_edge();
        bit c;
        c = model_carry();
        if (!m_armed) begin
            m_armed = 1'b1;
            m_pulse = 1'b0;
        end else begin
            m_pulse = c;
            if (bus.sync_clr)   m_count = IC;
            else if (bus.load)  m_count = int'(bus.load_val);
            else if (c)         m_count = int'(bus.rc_val);
            else if (bus.clk_en)
                m_count = bus.dir ? (m_count + MODV - 1) % MODV : (m_count + 1) % MODV;
        end
        for (int i = 0; i < NUM_CMP; i++) m_flag[i] = in_win(i, m_count);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_count"}, int'(bus.count), m_count);
        check({tag, "_tc_pulse"}, int'(bus.tc_pulse), int'(m_pulse));
        for (int i = 0; i < NUM_CMP; i++)
            check($sformatf("%s_cmp%0d", tag, i), int'(bus.cmp_in[i]),
                  int'(m_armed ? m_flag[i] : in_win(i, IC)));
    endtask

    task automatic tick(input string tag);
        #1;
        check({tag, "_carry"}, int'(bus.carry_out), int'(model_carry()));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic set_in(input bit en, input bit clr, input bit ld, input int lv,
                          input bit dir, input int tc, input int rc);
        bus.clk_en   = en;
        bus.sync_clr = clr;
        bus.load     = ld;
        bus.load_val = SIZE'(lv);
        bus.dir      = dir;
        bus.tc_val   = SIZE'(tc);
        bus.rc_val   = SIZE'(rc);
    endtask

    task automatic set_win(input int i, input int lo, input int hi);
        bus.cmp_lo[i*SIZE +: SIZE] = SIZE'(lo);
        bus.cmp_hi[i*SIZE +: SIZE] = SIZE'(hi);
    endtask

    initial begin
        int pulses, carries, first_pulse, last_pulse, hi0, hi1;

        // en clr ld lv dir tc rc | carry count pulse
        vecs[0]  = '{0, 0, 1,   5, 1,   3, 9, 0,   5, 0};
        vecs[1]  = '{1, 0, 0,   0, 1,   3, 9, 0,   4, 0};
        vecs[2]  = '{1, 0, 0,   0, 1,   3, 9, 0,   3, 0};
        vecs[3]  = '{1, 0, 0,   0, 1,   3, 9, 1,   9, 1};
        vecs[4]  = '{1, 0, 0,   0, 1,   3, 9, 0,   8, 0};
        vecs[5]  = '{1, 0, 0,   0, 1,   9, 9, 1,   9, 1};
        vecs[6]  = '{0, 0, 1, 799, 0, 799, 0, 0, 799, 0};
        vecs[7]  = '{1, 0, 1, 100, 0, 799, 0, 0, 100, 0};
        vecs[8]  = '{0, 0, 1, 799, 0, 799, 0, 0, 799, 0};
        vecs[9]  = '{1, 1, 1, 300, 0, 799, 0, 0,   0, 0};
        vecs[10] = '{0, 0, 1, 799, 0, 799, 0, 0, 799, 0};
        vecs[11] = '{1, 0, 0,   0, 0, 799, 0, 1,   0, 1};
        vecs[12] = '{0, 0, 1,   5, 0,   5, 5, 0,   5, 0};
        vecs[13] = '{1, 0, 0,   0, 0,   5, 5, 1,   5, 1};
        vecs[14] = '{1, 0, 0,   0, 0,   5, 5, 1,   5, 1};
        vecs[15] = '{0, 0, 0,   0, 0,   5, 5, 0,   5, 0};
        vecs[16] = '{1, 1, 0,   0, 0, 799, 0, 0,   0, 0};
        vecs[17] = '{1, 0, 0,   0, 0, 799, 0, 0,   1, 0};
        vecs[18] = '{1, 0, 0,   0, 1,   0, 7, 0,   0, 0};
        vecs[19] = '{1, 0, 0,   0, 1,   0, 7, 1,   7, 1};

        // Reset state with live window bounds
        rst_n = 1'b0;
        set_in(1, 0, 0, 0, DIR_UP, H_TOTAL_M1, 0);
        set_win(0, 0, 3);
        set_win(1, 10, 5);
        model_reset();
        #1;
        check("rst_count", int'(bus.count), IC);
        check("rst_tc_pulse", int'(bus.tc_pulse), 0);
        check("rst_cmp_live_in", int'(bus.cmp_in), 1);
        set_win(0, 1, 3);
        #1;
        check("rst_cmp_live_out", int'(bus.cmp_in), 0);
        set_win(0, H_SYNC_LO, H_SYNC_HI);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running horizontal period
        pulses = 0; carries = 0; first_pulse = -1; last_pulse = -1; hi0 = 0; hi1 = 0;
        for (int k = 1; k <= 1601; k++) begin
            #1;
            if (bus.carry_out) carries++;
            tick("period");
            if (bus.tc_pulse) begin
                pulses++;
                if (first_pulse < 0) first_pulse = k;
                else last_pulse = k;
            end
            if (bus.cmp_in[0]) hi0++;
            if (bus.cmp_in[1]) hi1++;
        end
        check("period_pulses", pulses, 2);
        check("period_carries", carries, 2);
        check("period_first_pulse", first_pulse, 801);
        check("period_length", last_pulse - first_pulse, 800);
        check("hsync_high_cycles", hi0, 192);
        check("empty_window_high", hi1, 0);

        // Directed vector table
        for (int v = 0; v < 20; v++) begin
            set_in(vecs[v].en, vecs[v].clr, vecs[v].ld, vecs[v].lv,
                   vecs[v].dir, vecs[v].tc, vecs[v].rc);
            #1;
            check($sformatf("vec%0d_carry", v), int'(bus.carry_out), int'(vecs[v].exp_carry));
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("vec%0d_count", v), int'(bus.count), vecs[v].exp_count);
            check($sformatf("vec%0d_tc_pulse", v), int'(bus.tc_pulse), int'(vecs[v].exp_pulse));
            for (int i = 0; i < NUM_CMP; i++)
                check($sformatf("vec%0d_cmp%0d", v, i), int'(bus.cmp_in[i]), int'(m_flag[i]));
        end

        // Async reset right after a terminal step, then delayed first step
        set_in(0, 0, 1, 799, DIR_UP, 799, 50);
        tick("pre_rst_load");
        set_in(1, 0, 0, 0, DIR_UP, 799, 50);
        tick("pre_rst_term");
        check("pre_rst_pulse", int'(bus.tc_pulse), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_count", int'(bus.count), IC);
        check("async_rst_tc_pulse", int'(bus.tc_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 0, 0, 0, DIR_UP, 799, 0);
        tick("rel_edge1");
        check("rel_first_edge_count", int'(bus.count), 0);
        tick("rel_edge2");
        check("rel_second_edge_count", int'(bus.count), 1);

        // Randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            bus.clk_en   = ($urandom_range(0, 9) != 0);
            bus.sync_clr = ($urandom_range(0, 99) < 2);
            bus.load     = ($urandom_range(0, 99) < 3);
            bus.load_val = SIZE'($urandom_range(0, MODV - 1));
            if ($urandom_range(0, 63) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 49) == 0) begin
                bus.tc_val = SIZE'($urandom_range(0, MODV - 1));
                bus.rc_val = SIZE'($urandom_range(0, MODV - 1));
            end
            if ($urandom_range(0, 199) == 0)
                set_win(int'($urandom_range(0, NUM_CMP - 1)),
                        int'($urandom_range(0, MODV - 1)), int'($urandom_range(0, MODV - 1)));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
